mem_refill_arbiter: RTL

Shares the single AXI read-address/read-data path of the cv32a6 memory subsystem between refill requesters (I-cache, D-cache, PTW). Each requester issues line-refill reads. The block round-robin arbitrates AR requests and tags each with the requester index as the AXI ID. It routes R beats back by ID and caps outstanding reads per requester. It sits between the cache subsystems and the AXI adapter.

---
 rtl/mem_refill_arbiter_pkg.sv | 25 ++
 rtl/mem_refill_arbiter_rr_arb_tree.sv | 57 +++++
 rtl/mem_refill_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_refill_arbiter_pkg.sv
// Shared refill definitions for the cache/PTW side of the memory subsystem.
//   - Refill port indices: which requester sits on which arbiter port.
//   - refill_req_t: one line-refill read request (address, AXI len).
//   - refill_rsp_t: one returned read beat (data, last).
package mem_refill_arbiter_pkg;

    localparam int unsigned ICACHE = 0;
    localparam int unsigned DCACHE = 1;
    localparam int unsigned PTW    = 2;

    localparam int unsigned REFILL_ADDR_W = 64;
    localparam int unsigned REFILL_DATA_W = 64;
    localparam int unsigned REFILL_LEN_W  = 8;

    typedef struct packed {
        logic [REFILL_ADDR_W-1:0] addr;
        logic [REFILL_LEN_W-1:0]  len;
    } refill_req_t;

    typedef struct packed {
        logic [REFILL_DATA_W-1:0] data;
        logic                     last;
    } refill_rsp_t;

endpackage

// File: rtl/mem_refill_arbiter_rr_arb_tree.sv
// Round-robin arbiter with no external lock.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : per-input request
//   gnt_o         : one-hot grant (combinational)
//   req_o         : some input is granted this cycle
//   idx_o         : index of the granted input
// The priority pointer holds the index with highest priority; after every
// grant it moves to the input following the granted one. A grant is assumed
// to be consumed in the cycle it is issued.
module rr_arb_tree #(
    parameter int unsigned NumIn = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumIn-1:0]           req_i,
    output logic [NumIn-1:0]           gnt_o,
    output logic                       req_o,
    output logic [$clog2(NumIn)-1:0]   idx_o
);

    localparam int unsigned IdxWidth = $clog2(NumIn);

    logic [IdxWidth-1:0] rr_q;
    logic [IdxWidth:0]   cand;
    logic [IdxWidth-1:0] cand_idx;

    // Scan inputs starting at the pointer, wrapping modulo NumIn.
    always_comb begin
        gnt_o    = '0;
        req_o    = 1'b0;
        idx_o    = '0;
        cand     = '0;
        cand_idx = '0;
        for (int unsigned off = 0; off < NumIn; off++) begin
            cand = {1'b0, rr_q} + (IdxWidth+1)'(off);
            if (cand >= (IdxWidth+1)'(NumIn)) begin
                cand = cand - (IdxWidth+1)'(NumIn);
            end
            cand_idx = cand[IdxWidth-1:0];
            if (!req_o && req_i[cand_idx]) begin
                req_o           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (req_o) begin
            rr_q <= (idx_o == IdxWidth'(NumIn - 1)) ? '0 : idx_o + IdxWidth'(1);
        end
    end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Refill read arbiter: shares one AXI AR/R path between refill requesters.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  : per-port refill request handshake
//   req_addr_i, req_len_i    : per-port request address and AXI len
//   ar_*                     : AXI read-address channel (id = port index)
//   r_*                      : AXI read-data channel
//   rsp_valid_o/rsp_ready_i  : per-port response beat handshake
//   rsp_data_o, rsp_last_o   : response beat payload, shared by all ports
//   bad_id_o                 : R beat carried an id with no matching port
//   idle_o                   : no AR pending and nothing outstanding
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; a valid source holds its payload stable until that edge, and
// ready may depend combinationally on valid.
module mem_refill_arbiter
    import mem_refill_arbiter_pkg::*;
#(
    parameter int unsigned NrPorts        = 3,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [NrPorts-1:0]                          req_valid_i,
    output logic [NrPorts-1:0]                          req_ready_o,
    input  logic [NrPorts-1:0][AddrWidth-1:0]           req_addr_i,
    input  logic [NrPorts-1:0][REFILL_LEN_W-1:0]        req_len_i,
    output logic                                        ar_valid_o,
    input  logic                                        ar_ready_i,
    output logic [AddrWidth-1:0]                        ar_addr_o,
    output logic [REFILL_LEN_W-1:0]                     ar_len_o,
    output logic [IdWidth-1:0]                          ar_id_o,
    input  logic                                        r_valid_i,
    output logic                                        r_ready_o,
    input  logic [IdWidth-1:0]                          r_id_i,
    input  logic [DataWidth-1:0]                        r_data_i,
    input  logic                                        r_last_i,
    output logic [NrPorts-1:0]                          rsp_valid_o,
    input  logic [NrPorts-1:0]                          rsp_ready_i,
    output logic [DataWidth-1:0]                        rsp_data_o,
    output logic                                        rsp_last_o,
    output logic                                        bad_id_o,
    output logic                                        idle_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam int unsigned PortIdxW = $clog2(NrPorts);

    localparam logic [0:0] AR_IDLE = 1'b0;
    localparam logic [0:0] AR_PEND = 1'b1;

    logic [0:0]                        ar_state_q;
    logic [AddrWidth-1:0]              ar_addr_q;
    logic [REFILL_LEN_W-1:0]           ar_len_q;
    logic [IdWidth-1:0]                ar_id_q;
    logic [NrPorts-1:0][CntWidth-1:0]  cnt_q;

    logic [NrPorts-1:0]  eligible;
    logic [NrPorts-1:0]  arb_req;
    logic [NrPorts-1:0]  arb_gnt;
    logic                arb_valid;
    logic [PortIdxW-1:0] arb_idx;
    logic                ar_hs;
    logic                r_last_hs;
    logic                r_id_ok;
    logic [NrPorts-1:0]  cnt_inc;
    logic [NrPorts-1:0]  cnt_dec;

    // A port at its outstanding cap is masked from arbitration.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NrPorts; i++) begin
            eligible[i] = req_valid_i[i] && (cnt_q[i] < CntWidth'(MaxOutstanding));
        end
    end

    // Requests only reach the arbiter while the AR register is empty, so a
    // grant is never issued in the cycle of an AR handshake.
    assign arb_req = (ar_state_q == AR_IDLE) ? eligible : '0;

    rr_arb_tree #(
        .NumIn (NrPorts)
    ) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (arb_req),
        .gnt_o  (arb_gnt),
        .req_o  (arb_valid),
        .idx_o  (arb_idx)
    );

    assign req_ready_o = arb_gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ar_state_q <= AR_IDLE;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_id_q    <= '0;
        end else begin
            case (ar_state_q)
                AR_IDLE: begin
                    if (arb_valid) begin
                        ar_addr_q  <= req_addr_i[arb_idx];
                        ar_len_q   <= req_len_i[arb_idx];
                        ar_id_q    <= IdWidth'(arb_idx);
                        ar_state_q <= AR_PEND;
                    end
                end
                AR_PEND: begin
                    if (ar_ready_i) begin
                        ar_state_q <= AR_IDLE;
                    end
                end
                default: ar_state_q <= AR_IDLE;
            endcase
        end
    end

    assign ar_valid_o = (ar_state_q == AR_PEND);
    assign ar_addr_o  = ar_addr_q;
    assign ar_len_o   = ar_len_q;
    assign ar_id_o    = ar_id_q;

    // R routing: ids beyond the last port are accepted and dropped.
    assign r_id_ok = ({1'b0, r_id_i} < (IdWidth+1)'(NrPorts));

    always_comb begin
        rsp_valid_o = '0;
        r_ready_o   = !r_id_ok;
        for (int i = 0; i < NrPorts; i++) begin
            if (r_id_i == IdWidth'(i)) begin
                rsp_valid_o[i] = r_valid_i;
                r_ready_o      = rsp_ready_i[i];
            end
        end
    end

    assign rsp_data_o = r_data_i;
    assign rsp_last_o = r_last_i;
    assign bad_id_o   = r_valid_i && !r_id_ok;

    // Outstanding counters: +1 on AR handshake, -1 on the last R beat.
    assign ar_hs     = ar_valid_o && ar_ready_i;
    assign r_last_hs = r_valid_i && r_ready_o && r_last_i && r_id_ok;

    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int i = 0; i < NrPorts; i++) begin
            cnt_inc[i] = ar_hs && (ar_id_q == IdWidth'(i));
            cnt_dec[i] = r_last_hs && (r_id_i == IdWidth'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NrPorts; i++) begin
                if (cnt_inc[i] && !cnt_dec[i] && (cnt_q[i] != CntWidth'(MaxOutstanding))) begin
                    cnt_q[i] <= cnt_q[i] + CntWidth'(1);
                end else if (cnt_dec[i] && !cnt_inc[i] && (cnt_q[i] != '0)) begin
                    cnt_q[i] <= cnt_q[i] - CntWidth'(1);
                end
            end
        end
    end

    assign idle_o = (ar_state_q == AR_IDLE) && (cnt_q == '0);

    // Saturation is a safety net only: overflow cannot happen while masking
    // works, underflow means the slave returned a last beat nobody asked for.
    for (genvar g = 0; g < NrPorts; g++) begin : g_cnt_chk
        a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(cnt_inc[g] && !cnt_dec[g] && (cnt_q[g] == CntWidth'(MaxOutstanding))));
        a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(cnt_dec[g] && !cnt_inc[g] && (cnt_q[g] == '0)));
    end

endmodule
